mem_access_stage: RTL

- MEM stage of the pipelined MIPS core. Sits between the EX/MEM register and the MEM/WB register.
- Performs loads and stores against a handshaked data-memory port. Supports byte, halfword and word accesses, with lane steering and load sign/zero extension.
- Stalls the pipeline while an access is outstanding. Produces RegWrite, MemtoReg, ALUresult, readData and writeReg for the MEM/WB register.

---
 rtl/mem_access_stage.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined MIPS core.
// Handshaked data-memory access with lane steering and load extension.
module mem_access_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  memSize,
    input  logic        memSigned,
    input  logic [31:0] ALUresult,
    input  logic [31:0] writeData,
    input  logic [4:0]  writeReg,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    output logic [3:0]  memBe,
    input  logic        memGnt,
    input  logic        memRvalid,
    input  logic [31:0] memRdata,
    output logic        stall,
    output logic        RegWriteOut,
    output logic        MemtoRegOut,
    output logic [31:0] ALUresultOut,
    output logic [31:0] readDataOut,
    output logic [4:0]  writeRegOut,
    output logic        misalignErr,
    output logic        busErr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic             err_q;
    logic             err_d;

    logic [1:0]       a;
    logic             is_byte;
    logic             is_half;
    logic             is_word;
    logic             aligned;
    logic             is_mem;
    logic             mem_op;
    logic             misalign;
    logic             is_load;
    logic             tmo;
    logic             fwd;
    logic [7:0]       ld_b;
    logic [15:0]      ld_h;
    logic [31:0]      ld_ext;

    assign a        = ALUresult[1:0];
    assign is_byte  = (memSize == 2'b00);
    assign is_half  = (memSize == 2'b01);
    assign is_word  = (memSize == 2'b10);
    assign aligned  = is_byte
                    | (is_half & ~a[0])
                    | (is_word & (a == 2'b00));
    assign is_mem   = valid & (MemRead | MemWrite);
    assign mem_op   = is_mem & aligned;
    assign misalign = is_mem & ~aligned & (state == IDLE);
    assign is_load  = MemRead & ~MemWrite;
    assign tmo      = (cnt >= CNT_W'(TIMEOUT - 1));

    // Store lane steering: replicate data, enable only the addressed lanes.
    always_comb begin
        memWdata = writeData;
        memBe    = 4'b0000;
        unique case (1'b1)
            is_byte: begin
                memWdata = {4{writeData[7:0]}};
                memBe    = 4'b0001 << a;
            end
            is_half: begin
                memWdata = {2{writeData[15:0]}};
                memBe    = a[1] ? 4'b1100 : 4'b0011;
            end
            is_word: begin
                memWdata = writeData;
                memBe    = 4'b1111;
            end
            default: begin
                memWdata = writeData;
                memBe    = 4'b0000;
            end
        endcase
    end

    // Load extraction from the captured word and sign/zero extension.
    always_comb begin
        ld_b = rdata_q[7:0];
        unique case (a)
            2'd0: ld_b = rdata_q[7:0];
            2'd1: ld_b = rdata_q[15:8];
            2'd2: ld_b = rdata_q[23:16];
            2'd3: ld_b = rdata_q[31:24];
            default: ld_b = rdata_q[7:0];
        endcase
        ld_h   = a[1] ? rdata_q[31:16] : rdata_q[15:0];
        ld_ext = rdata_q;
        unique case (1'b1)
            is_byte: ld_ext = {{24{memSigned & ld_b[7]}}, ld_b};
            is_half: ld_ext = {{16{memSigned & ld_h[15]}}, ld_h};
            default: ld_ext = rdata_q;
        endcase
    end

    // Access FSM: next state, request/stall, data capture, timeout.
    always_comb begin
        nxt     = state;
        memReq  = 1'b0;
        stall   = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = '0;
        unique case (state)
            IDLE: begin
                err_d = 1'b0;
                if (mem_op && rst_n) begin
                    memReq = 1'b1;
                    stall  = 1'b1;
                    if (memGnt) nxt = MemWrite ? DONE : WAIT;
                    else        nxt = REQ;
                end
            end
            REQ: begin
                memReq = 1'b1;
                stall  = 1'b1;
                if (memGnt) begin
                    nxt = MemWrite ? DONE : WAIT;
                end else if (tmo) begin
                    nxt   = DONE;
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (memRvalid) begin
                    rdata_d = memRdata;
                    nxt     = DONE;
                end else if (tmo) begin
                    nxt   = DONE;
                    err_d = 1'b1;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
        if ((state == REQ || state == WAIT) &&
            (nxt == REQ || nxt == WAIT))
            cnt_d = cnt + CNT_W'(1);
    end

    // State, timeout counter, read data and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign memAddr      = {ALUresult[31:2], 2'b00};
    assign memWe        = memReq & MemWrite;
    assign busErr       = (state == DONE) & err_q;
    assign misalignErr  = misalign;

    // While stalled the MEM/WB register receives a bubble.
    assign fwd          = valid & ~stall;
    assign RegWriteOut  = fwd & RegWrite & ~misalign & ~busErr;
    assign MemtoRegOut  = fwd & MemtoReg;
    assign ALUresultOut = fwd ? ALUresult : 32'h0;
    assign writeRegOut  = fwd ? writeReg : 5'h0;
    assign readDataOut  = (state == DONE && is_load && !err_q) ?
                          ld_ext : 32'h0;

endmodule
